// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared widths and depths for the processor I/O port unit
package io_pkg;
    localparam int IO_WIDTH      = 16;
    localparam int IO_FIFO_DEPTH = 4;
    localparam int IO_PTR_W      = $clog2(IO_FIFO_DEPTH);
endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with combinational head and occupancy count
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Fullness and emptiness come from the pre-edge count, so a same-cycle
    // pop never frees a slot for a same-cycle push.
    assign full      = (r_count == FULL_CNT);
    assign empty     = (r_count == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign head      = r_mem[r_rd_ptr];
    assign count     = r_count;

    always_ff @(posedge clk) begin
        if (reset && w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/io_port_unit.sv
// rtl/io_port_unit.sv - processor OUT/IN port unit: two FIFOs plus handshake and stall logic
module io_port_unit
    import io_pkg::*;
#(
    parameter int WIDTH = IO_WIDTH,
    parameter int DEPTH = IO_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             out_en,
    input  logic [WIDTH-1:0] out_data,
    input  logic             in_en,
    output logic [WIDTH-1:0] in_data,
    output logic             io_stall,
    output logic [WIDTH-1:0] port_out_data,
    output logic             port_out_valid,
    input  logic             port_out_ready,
    input  logic [WIDTH-1:0] port_in_data,
    input  logic             port_in_valid,
    output logic             port_in_ready
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] w_out_head;
    logic [CNT_W-1:0] w_out_count;
    logic             w_out_full;
    logic             w_out_empty;
    logic             w_out_push;
    logic             w_out_pop;

    logic [WIDTH-1:0] w_in_head;
    logic [CNT_W-1:0] w_in_count;
    logic             w_in_full;
    logic             w_in_empty;
    logic             w_in_push;
    logic             w_in_pop;

    // Every handshake is qualified by reset so nothing completes in a reset cycle.
    assign w_out_push     = reset && out_en && !w_out_full;
    assign w_out_pop      = reset && port_out_ready && !w_out_empty;
    assign port_out_valid = reset && (w_out_count != '0);
    assign port_out_data  = w_out_head;

    assign port_in_ready  = reset && (w_in_count < CNT_W'(DEPTH));
    assign w_in_push      = reset && port_in_valid && !w_in_full;
    assign w_in_pop       = reset && in_en && !w_in_empty;
    assign in_data        = w_in_pop ? w_in_head : '0;

    assign io_stall = reset && ((out_en && w_out_full) || (in_en && w_in_empty));

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_out_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_out_push),
        .wdata (out_data),
        .pop   (w_out_pop),
        .head  (w_out_head),
        .count (w_out_count),
        .full  (w_out_full),
        .empty (w_out_empty)
    );

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_in_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_in_push),
        .wdata (port_in_data),
        .pop   (w_in_pop),
        .head  (w_in_head),
        .count (w_in_count),
        .full  (w_in_full),
        .empty (w_in_empty)
    );
endmodule

// File: tb/tb_io_port_unit.sv
// tb/tb_io_port_unit.sv - table-driven bench for io_port_unit
module tb_io_port_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        out_en;
    logic [15:0] out_data;
    logic        in_en;
    logic [15:0] in_data;
    logic        io_stall;
    logic [15:0] port_out_data;
    logic        port_out_valid;
    logic        port_out_ready;
    logic [15:0] port_in_data;
    logic        port_in_valid;
    logic        port_in_ready;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        rst;
        logic        oe;
        logic [15:0] od;
        logic        ie;
        logic        por;
        logic [15:0] pid;
        logic        piv;
        logic        x_stall;
        logic        x_pov;
        logic [15:0] x_pod;
        logic        x_pir;
        logic [15:0] x_ind;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    io_port_unit #(.WIDTH(16), .DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .out_en         (out_en),
        .out_data       (out_data),
        .in_en          (in_en),
        .in_data        (in_data),
        .io_stall       (io_stall),
        .port_out_data  (port_out_data),
        .port_out_valid (port_out_valid),
        .port_out_ready (port_out_ready),
        .port_in_data   (port_in_data),
        .port_in_valid  (port_in_valid),
        .port_in_ready  (port_in_ready)
    );

    task automatic chk(input string nm, input int row, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d got=%h exp=%h", nm, row, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic oe, input logic [15:0] od, input logic ie,
                       input logic por, input logic [15:0] pid, input logic piv,
                       input logic s, input logic v, input logic [15:0] d, input logic r,
                       input logic [15:0] ind);
        vec_t t;
        t.rst = rst; t.oe = oe; t.od = od; t.ie = ie; t.por = por; t.pid = pid; t.piv = piv;
        t.x_stall = s; t.x_pov = v; t.x_pod = d; t.x_pir = r; t.x_ind = ind;
        vecs.push_back(t);
    endtask

    task automatic drive(input vec_t t);
        @(posedge clk);
        #1;
        reset = t.rst; out_en = t.oe; out_data = t.od; in_en = t.ie;
        port_out_ready = t.por; port_in_data = t.pid; port_in_valid = t.piv;
    endtask

    task automatic apply_and_check(input vec_t t, input int row);
        drive(t);
        @(negedge clk);
        chk("io_stall", row, {15'd0, io_stall}, {15'd0, t.x_stall});
        chk("port_out_valid", row, {15'd0, port_out_valid}, {15'd0, t.x_pov});
        if (t.x_pov) chk("port_out_data", row, port_out_data, t.x_pod);
        chk("port_in_ready", row, {15'd0, port_in_ready}, {15'd0, t.x_pir});
        chk("in_data", row, in_data, t.x_ind);
    endtask

    initial begin
        vec_t h;
        reset = 1'b0; out_en = 1'b0; out_data = '0; in_en = 1'b0;
        port_out_ready = 1'b0; port_in_data = '0; port_in_valid = 1'b0;

        // reset with pending requests, then release
        add(0, 1, 16'h0055, 1, 1, 16'h1111, 1,  0, 0, 16'h0000, 0, 16'h0000);
        add(0, 1, 16'h0055, 1, 1, 16'h1111, 1,  0, 0, 16'h0000, 0, 16'h0000);
        add(1, 0, 16'h0000, 0, 0, 16'h0000, 0,  0, 0, 16'h0000, 1, 16'h0000);
        // fill OUT, overflow attempt, pop-while-full, drain in order
        add(1, 1, 16'h0001, 0, 0, 16'h0000, 0,  0, 0, 16'h0000, 1, 16'h0000);
        add(1, 1, 16'h0002, 0, 0, 16'h0000, 0,  0, 1, 16'h0001, 1, 16'h0000);
        add(1, 1, 16'h0003, 0, 0, 16'h0000, 0,  0, 1, 16'h0001, 1, 16'h0000);
        add(1, 1, 16'h0004, 0, 0, 16'h0000, 0,  0, 1, 16'h0001, 1, 16'h0000);
        add(1, 1, 16'h0005, 0, 0, 16'h0000, 0,  1, 1, 16'h0001, 1, 16'h0000);
        add(1, 1, 16'h0005, 0, 1, 16'h0000, 0,  1, 1, 16'h0001, 1, 16'h0000);
        add(1, 0, 16'h0000, 0, 1, 16'h0000, 0,  0, 1, 16'h0002, 1, 16'h0000);
        add(1, 0, 16'h0000, 0, 1, 16'h0000, 0,  0, 1, 16'h0003, 1, 16'h0000);
        add(1, 0, 16'h0000, 0, 1, 16'h0000, 0,  0, 1, 16'h0004, 1, 16'h0000);
        add(1, 0, 16'h0000, 0, 1, 16'h0000, 0,  0, 0, 16'h0000, 1, 16'h0000);
        // IN on empty FIFO with same-cycle arrival
        add(1, 0, 16'h0000, 1, 0, 16'hBEEF, 1,  1, 0, 16'h0000, 1, 16'h0000);
        add(1, 0, 16'h0000, 1, 0, 16'h0000, 0,  0, 0, 16'h0000, 1, 16'hBEEF);
        add(1, 0, 16'h0000, 1, 0, 16'h0000, 0,  1, 0, 16'h0000, 1, 16'h0000);
        // simultaneous OUT and IN, IN stalled, OUT accepted
        add(1, 1, 16'h00AA, 1, 0, 16'h0000, 0,  1, 0, 16'h0000, 1, 16'h0000);
        add(1, 0, 16'h0000, 0, 1, 16'h0000, 0,  0, 1, 16'h00AA, 1, 16'h0000);
        add(1, 0, 16'h0000, 0, 0, 16'h0000, 0,  0, 0, 16'h0000, 1, 16'h0000);
        // six words through IN with pointer wrap
        add(1, 0, 16'h0000, 0, 0, 16'hA000, 1,  0, 0, 16'h0000, 1, 16'h0000);
        add(1, 0, 16'h0000, 0, 0, 16'hA001, 1,  0, 0, 16'h0000, 1, 16'h0000);
        add(1, 0, 16'h0000, 0, 0, 16'hA002, 1,  0, 0, 16'h0000, 1, 16'h0000);
        add(1, 0, 16'h0000, 0, 0, 16'hA003, 1,  0, 0, 16'h0000, 1, 16'h0000);
        add(1, 0, 16'h0000, 0, 0, 16'hA004, 1,  0, 0, 16'h0000, 0, 16'h0000);
        add(1, 0, 16'h0000, 1, 0, 16'hA004, 1,  0, 0, 16'h0000, 0, 16'hA000);
        add(1, 0, 16'h0000, 1, 0, 16'hA004, 1,  0, 0, 16'h0000, 1, 16'hA001);
        add(1, 0, 16'h0000, 1, 0, 16'hA005, 1,  0, 0, 16'h0000, 1, 16'hA002);
        add(1, 0, 16'h0000, 1, 0, 16'h0000, 0,  0, 0, 16'h0000, 1, 16'hA003);
        add(1, 0, 16'h0000, 1, 0, 16'h0000, 0,  0, 0, 16'h0000, 1, 16'hA004);
        add(1, 0, 16'h0000, 1, 0, 16'h0000, 0,  0, 0, 16'h0000, 1, 16'hA005);
        add(1, 0, 16'h0000, 1, 0, 16'h0000, 0,  1, 0, 16'h0000, 1, 16'h0000);
        // three entries in each FIFO, then reset mid-operation
        add(1, 1, 16'h0B01, 0, 0, 16'h0C01, 1,  0, 0, 16'h0000, 1, 16'h0000);
        add(1, 1, 16'h0B02, 0, 0, 16'h0C02, 1,  0, 1, 16'h0B01, 1, 16'h0000);
        add(1, 1, 16'h0B03, 0, 0, 16'h0C03, 1,  0, 1, 16'h0B01, 1, 16'h0000);
        add(0, 1, 16'h0B04, 1, 1, 16'h0C04, 1,  0, 0, 16'h0000, 0, 16'h0000);
        add(1, 0, 16'h0000, 1, 0, 16'h0000, 0,  1, 0, 16'h0000, 1, 16'h0000);
        add(1, 0, 16'h0000, 0, 0, 16'h0000, 0,  0, 0, 16'h0000, 1, 16'h0000);

        for (int i = 0; i < vecs.size(); i++) begin
            apply_and_check(vecs[i], i);
        end

        // streaming OUT: continuous push with pop keeps one entry in flight
        for (int i = 0; i < 6; i++) begin
            h = '{rst: 1'b1, oe: 1'b1, od: 16'h3000 + 16'(i), ie: 1'b0, por: 1'b1,
                  pid: 16'h0000, piv: 1'b0, x_stall: 1'b0, x_pov: (i > 0),
                  x_pod: 16'h3000 + 16'(i) - 16'h0001, x_pir: 1'b1, x_ind: 16'h0000};
            apply_and_check(h, 100 + i);
        end
        h = '{rst: 1'b1, oe: 1'b0, od: 16'h0000, ie: 1'b0, por: 1'b1, pid: 16'h0000, piv: 1'b0,
              x_stall: 1'b0, x_pov: 1'b1, x_pod: 16'h3005, x_pir: 1'b1, x_ind: 16'h0000};
        apply_and_check(h, 106);
        h.x_pov = 1'b0;
        apply_and_check(h, 107);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/io_port_unit.md
IO_PORT_UNIT -- requirements
Module: io_port_unit

Interface
REQ-001 Parameter WIDTH, default 16: data width of both ports.
REQ-002 Parameter DEPTH, default 4: entries per FIFO; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 out_en  input  1  OUT instruction in write-back; request to push out_data.
REQ-006 out_data  input  WIDTH  write-back data for OUT.
REQ-007 in_en  input  1  IN instruction needs input data this cycle.
REQ-008 in_data  output  WIDTH  data returned to the IN instruction.
REQ-009 io_stall  output  1  processor shall hold its pipeline this cycle.
REQ-010 port_out_data  output  WIDTH  head of OUT FIFO toward the external sink.
REQ-011 port_out_valid  output  1  port_out_data valid.
REQ-012 port_out_ready  input  1  external sink accepts.
REQ-013 port_in_data  input  WIDTH  external source data.
REQ-014 port_in_valid  input  1  port_in_data valid.
REQ-015 port_in_ready  output  1  unit accepts port_in_data.

Function
REQ-016 OUT FIFO push occurs when out_en=1 and OUT count<DEPTH; the fullness test uses the pre-edge count, so a pop in the same cycle does not unblock a push.
REQ-017 port_out_valid = (OUT count != 0); port_out_data = OUT head, combinational from storage.
REQ-018 OUT pop occurs when port_out_valid and port_out_ready are both 1.
REQ-019 Latency from accepted out_en to port_out_valid=1 (empty FIFO) is 1 cycle.
REQ-020 port_in_ready = (IN count<DEPTH) and reset=1; IN push occurs when port_in_valid and port_in_ready are both 1.
REQ-021 When in_en=1 and IN count!=0: in_data = IN head (combinational) and IN pops at the edge.
REQ-022 When IN count=0: in_data = 0, no pop; a push in the same cycle appears on in_data 1 cycle later.
REQ-023 io_stall = (out_en and OUT full) or (in_en and IN empty); combinational, no state change for the stalled request.
REQ-024 Simultaneous push and pop on a non-empty, non-full FIFO: both occur and the count is unchanged.
REQ-025 Simultaneous out_en and in_en: each is evaluated independently; io_stall is the OR of both conditions.
REQ-026 Read/write pointers are log2(DEPTH) bits wide and wrap modulo DEPTH; count is log2(DEPTH)+1 bits and ranges 0..DEPTH.
REQ-027 FIFO order is strictly first-in first-out; no data is dropped or duplicated.

Reset
REQ-028 While reset=0 at an edge: pointers and counts become 0 and both FIFOs become empty.
REQ-029 While reset=0: port_out_valid=0, port_in_ready=0, io_stall=0, in_data=0, regardless of inputs.
REQ-030 Reset mid-operation discards all queued data; no handshake completes in the reset cycle.
REQ-031 First cycle after release: port_in_ready=1, port_out_valid=0.

Structure
REQ-032 Shared package io_pkg holds IO_WIDTH=16, IO_FIFO_DEPTH=4, and derived IO_PTR_W=2.
REQ-033 A single sub-module sync_fifo (parameters WIDTH, DEPTH; push, pop, head, count, full, empty) is instantiated twice, once for OUT and once for IN.
REQ-034 io_port_unit contains only the handshake, stall, and muxing logic around the two sync_fifo instances.

Verification
REQ-035 Reset with port_in_valid=1 and out_en=1 -> no push; port_in_ready=0 and port_out_valid=0; after release, port_in_ready=1.
REQ-036 out_en for 4 cycles with data 0x0001..0x0004 and port_out_ready=0; 5th out_en with 0x0005 -> io_stall=1 and count stays 4; then port_out_ready=1 -> port_out_data 0x0001,0x0002,… in order.
REQ-037 Full OUT FIFO, out_en=1 and port_out_ready=1 in the same cycle -> pop of 0x0001, push rejected, io_stall=1, count=3.
REQ-038 in_en=1 on empty IN with port_in_valid=1 carrying 0xBEEF in the same cycle -> io_stall=1 and in_data=0; next cycle in_data=0xBEEF, io_stall=0, pop occurs.
REQ-039 Push 6 words 0xA000..0xA005 through IN with interleaved in_en pops -> pointers wrap and values are returned in order with none lost.
REQ-040 Reset asserted with 3 entries in each FIFO -> both empty after release; port_out_valid=0; in_en=1 produces io_stall=1.
